spm_dp_be: RTL and testbench
============================

// Module: spm_dp_be
// PURPOSE
//  Parametrised dual-port scratchpad: port A serves IF, port B serves MEM, both on one clock.
//  Adds byte-lane write enables, registered reads with valid strobes, and deterministic
//  same-address collision resolution. A post-reset clear FSM zeroes every word before the
//  first access is accepted.
// PARAMETERS
//  DATA_W  32  word width in bits; must be a multiple of 8
//  ADDR_W  12  word address width; DEPTH = 2**ADDR_W words
//  BE_W    DATA_W/8  byte-lane count (derived, not overridden)
// PORTS
//  clk           in   1       single clock, rising edge
//  reset         in   1       asynchronous, active-high
//  init_busy     out  1       1 while the clear FSM runs; no access is accepted
//  a_as_         in   1       port A strobe, active-low
//  a_rw          in   1       1=READ, 0=WRITE
//  a_be          in   BE_W    port A byte enables (writes only)
//  a_addr        in   ADDR_W  port A word address
//  a_wr_data     in   DATA_W  port A write data
//  a_rd_data     out  DATA_W  port A read data, registered
//  a_rd_valid    out  1       port A read data valid, one-cycle pulse
//  a_wr_conflict out  1       pulse: port A lanes lost to a port B write
//  b_*           --   --      port B: same set and widths as a_* except no b_wr_conflict
// BEHAVIOUR
//  Reset values: a/b_rd_data=0, a/b_rd_valid=0, a_wr_conflict=0, init_busy=1, clear ptr=0.
//  FSM states: CLEAR -> RUN.
//   CLEAR: writes 0 to word ptr each cycle, ptr++; on ptr==DEPTH-1, next state is RUN.
//     init_busy=1 throughout. DEPTH cycles total. Strobes ignored: no write, no valid.
//   RUN: init_busy=0. Accesses are accepted every cycle, no back-pressure.
//  Reset asserted mid-CLEAR or mid-RUN: async return to CLEAR with ptr=0. Outputs are
//   forced to their reset values and in-flight reads are dropped (valid never pulses).
//  Access acceptance: as_==0 in RUN at a clk edge.
//  Read: rd_data and rd_valid update at edge N+1 for a request sampled at edge N (latency 1).
//   rd_valid=0 on idle cycles. rd_data holds its last value when not valid.
//  Write: bytes with be[i]=1 are written at the sampled edge. be==0 is a legal no-op write.
//  Both ports write the same address in one cycle: port B lanes win. Port A lanes are
//   written only where b_be[i]=0. a_wr_conflict pulses at N+1 iff (a_be & b_be)!=0.
//  Read on one port, write on the other, same address, same cycle:
//   ordering is set by SPM_FWD_EN (see CONFIGURATION).
//  Non-colliding addresses: both ports fully independent.
//  Address is exactly ADDR_W bits wide, so out-of-range access is impossible. No wrap logic.
// CONFIGURATION
//  SPM_FWD_EN defined: write-first cross-port forwarding. A read returns the merged word:
//   written lanes come from the other port's wr_data, the remaining lanes from memory.
//  SPM_FWD_EN undefined: read-first. A colliding read returns the pre-write word.
//   No bypass mux is built.
//  Collision and conflict rules between two writes are identical in both builds.
// TESTING
//  1. Release reset -> init_busy=1 for exactly 2**ADDR_W cycles, then 0. A read of any
//     address afterwards returns 0 with rd_valid=1 one cycle after the request.
//  2. A writes 0xDEADBEEF @0x010 with be=4'hF; next cycle B reads 0x010
//     -> b_rd_data=0xDEADBEEF, b_rd_valid=1 one cycle later.
//  3. Same cycle: A writes 0x11223344 be=4'hF and B writes 0xAABBCCDD be=4'h3, both @0x020
//     -> word=0x1122CCDD; a_wr_conflict=1 for one cycle.
//  4. Word @0x030=0x0; same cycle: A writes 0x55667788 be=4'hC, B reads @0x030
//     -> b_rd_data=0x55660000 with SPM_FWD_EN, 0x00000000 without.
//  5. Assert reset at CLEAR ptr=100 -> init_busy stays 1, ptr restarts at 0,
//     and a full DEPTH clear completes. Asserting reset with a read in flight -> rd_valid never pulses.
//  6. Back-to-back reads on both ports every cycle to distinct addresses
//     -> rd_valid high continuously, data in request order, no stalls.

Source files
------------

// File: rtl/spm_dp_be.sv
// Dual-port byte-enabled scratchpad with registered reads and a post-reset clear sequencer.
// Optional build macro SPM_FWD_EN: write-first cross-port forwarding (read-first when undefined).
module spm_dp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  localparam int BE_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_busy,
  input  logic              a_as_,
  input  logic              a_rw,
  input  logic [BE_W-1:0]   a_be,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wr_data,
  output logic [DATA_W-1:0] a_rd_data,
  output logic              a_rd_valid,
  output logic              a_wr_conflict,
  input  logic              b_as_,
  input  logic              b_rw,
  input  logic [BE_W-1:0]   b_be,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wr_data,
  output logic [DATA_W-1:0] b_rd_data,
  output logic              b_rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;

  logic run;
  logic a_re, a_we, b_re, b_we;
  logic same_addr;
  logic [DATA_W-1:0] a_rd_word, b_rd_word;

`ifdef SPM_FWD_EN
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] base,
    input logic [DATA_W-1:0] wr,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] r;
    r = base;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        r[8*i +: 8] = wr[8*i +: 8];
      end
    end
    return r;
  endfunction
`endif

  assign run       = (state == ST_RUN);
  assign init_busy = (state == ST_CLEAR);

  always_comb begin
    a_re      = run && !a_as_ && a_rw;
    a_we      = run && !a_as_ && !a_rw;
    b_re      = run && !b_as_ && b_rw;
    b_we      = run && !b_as_ && !b_rw;
    same_addr = (a_addr == b_addr);
  end

  // Read word selection; the forwarding build overlays the other port's same-cycle write lanes.
  always_comb begin
`ifdef SPM_FWD_EN
    a_rd_word = merge_lanes(mem[a_addr], b_wr_data,
                            (b_we && same_addr) ? b_be : {BE_W{1'b0}});
    b_rd_word = merge_lanes(mem[b_addr], a_wr_data,
                            (a_we && same_addr) ? a_be : {BE_W{1'b0}});
`else
    a_rd_word = mem[a_addr];
    b_rd_word = mem[b_addr];
`endif
  end

  // Clear sequencer: walks every word once after reset, then opens the ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_CLEAR;
      ptr   <= {ADDR_W{1'b0}};
    end else if (state == ST_CLEAR) begin
      ptr <= ptr + PTR_ONE;
      if (ptr == PTR_LAST) begin
        state <= ST_RUN;
      end
    end
  end

  // Storage writes; a port A lane is dropped where port B writes the same lane of the same word.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[ptr] <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < BE_W; i++) begin
        if (a_we && a_be[i] && !(b_we && same_addr && b_be[i])) begin
          mem[a_addr][8*i +: 8] <= a_wr_data[8*i +: 8];
        end
        if (b_we && b_be[i]) begin
          mem[b_addr][8*i +: 8] <= b_wr_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read results and the write-conflict pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rd_data     <= {DATA_W{1'b0}};
      b_rd_data     <= {DATA_W{1'b0}};
      a_rd_valid    <= 1'b0;
      b_rd_valid    <= 1'b0;
      a_wr_conflict <= 1'b0;
    end else begin
      a_rd_valid    <= a_re;
      b_rd_valid    <= b_re;
      a_wr_conflict <= a_we && b_we && same_addr && (|(a_be & b_be));
      if (a_re) begin
        a_rd_data <= a_rd_word;
      end
      if (b_re) begin
        b_rd_data <= b_rd_word;
      end
    end
  end

endmodule

// File: tb/tb_spm_dp_be.sv
// Self-checking bench for spm_dp_be: vector table plus read scoreboards and reset/clear sequences.
module tb_spm_dp_be;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int BE_W   = 4;
  localparam int DEPTH  = 256;
`ifdef SPM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic ON  = 1'b0;
  localparam logic OFF = 1'b1;
  localparam logic R   = 1'b1;
  localparam logic W   = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              init_busy;
  logic              a_as_, a_rw, b_as_, b_rw;
  logic [BE_W-1:0]   a_be, b_be;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wr_data, b_wr_data, a_rd_data, b_rd_data;
  logic              a_rd_valid, b_rd_valid, a_wr_conflict;

  spm_dp_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .init_busy(init_busy),
    .a_as_(a_as_), .a_rw(a_rw), .a_be(a_be), .a_addr(a_addr), .a_wr_data(a_wr_data),
    .a_rd_data(a_rd_data), .a_rd_valid(a_rd_valid), .a_wr_conflict(a_wr_conflict),
    .b_as_(b_as_), .b_rw(b_rw), .b_be(b_be), .b_addr(b_addr), .b_wr_data(b_wr_data),
    .b_rd_data(b_rd_data), .b_rd_valid(b_rd_valid)
  );

  typedef struct {
    logic        a_as;
    logic        a_rw;
    logic [3:0]  a_be;
    logic [7:0]  a_addr;
    logic [31:0] a_wd;
    logic        b_as;
    logic        b_rw;
    logic [3:0]  b_be;
    logic [7:0]  b_addr;
    logic [31:0] b_wd;
    logic [31:0] a_exp;
    logic [31:0] b_exp;
    logic        conf;
  } vec_t;

  vec_t        tbl [18];
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] last_a, last_b;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_as_ = 1'b1; a_rw = 1'b1; a_be = 4'h0; a_addr = 8'h00; a_wr_data = 32'h0;
    b_as_ = 1'b1; b_rw = 1'b1; b_be = 4'h0; b_addr = 8'h00; b_wr_data = 32'h0;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] e;
    chk({tag, ":a_rd_valid"}, 32'(a_rd_valid), 32'(qa.size() != 0));
    if (qa.size() != 0) begin
      e = qa.pop_front();
      last_a = e;
    end
    chk({tag, ":a_rd_data"}, a_rd_data, last_a);
    chk({tag, ":b_rd_valid"}, 32'(b_rd_valid), 32'(qb.size() != 0));
    if (qb.size() != 0) begin
      e = qb.pop_front();
      last_b = e;
    end
    chk({tag, ":b_rd_data"}, b_rd_data, last_b);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    a_as_ = v.a_as; a_rw = v.a_rw; a_be = v.a_be; a_addr = v.a_addr; a_wr_data = v.a_wd;
    b_as_ = v.b_as; b_rw = v.b_rw; b_be = v.b_be; b_addr = v.b_addr; b_wr_data = v.b_wd;
    if (!v.a_as && v.a_rw) qa.push_back(v.a_exp);
    if (!v.b_as && v.b_rw) qb.push_back(v.b_exp);
    @(posedge clk);
    #1;
    check_outputs(tag);
    chk({tag, ":a_wr_conflict"}, 32'(a_wr_conflict), 32'(v.conf));
  endtask

  // Runs the clear phase with strobes asserted (they must be ignored), counting busy cycles.
  task automatic count_busy(input int max_n, output int n, output int spur);
    n = 0;
    spur = 0;
    a_as_ = 1'b0; a_rw = 1'b1; a_addr = 8'h10;
    b_as_ = 1'b0; b_rw = 1'b0; b_be = 4'hF; b_addr = 8'h05; b_wr_data = 32'hFFFFFFFF;
    while (init_busy === 1'b1 && n < max_n) begin
      n++;
      @(posedge clk);
      #1;
      if (a_rd_valid !== 1'b0 || b_rd_valid !== 1'b0) spur++;
    end
    idle_inputs();
  endtask

  task automatic reset_model();
    qa.delete();
    qb.delete();
    last_a = 32'h0;
    last_b = 32'h0;
  endtask

  int   n_busy, n_spur;
  vec_t v;

  initial begin
    tbl[0]  = '{ON, R, 4'h0, 8'hFF, 32'h0,        ON,  R, 4'h0, 8'h05, 32'h0,        32'h0, 32'h0, 1'b0};
    tbl[1]  = '{ON, W, 4'hF, 8'h10, 32'hDEADBEEF, OFF, R, 4'h0, 8'h00, 32'h0,        32'h0, 32'h0, 1'b0};
    tbl[2]  = '{ON, R, 4'h0, 8'h00, 32'h0,        ON,  R, 4'h0, 8'h10, 32'h0,        32'h0, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{ON, W, 4'hF, 8'h20, 32'h11223344, ON,  W, 4'h3, 8'h20, 32'hAABBCCDD, 32'h0, 32'h0, 1'b1};
    tbl[4]  = '{ON, R, 4'h0, 8'h20, 32'h0,        OFF, R, 4'h0, 8'h00, 32'h0,        32'h1122CCDD, 32'h0, 1'b0};
    tbl[5]  = '{ON, W, 4'hC, 8'h30, 32'h55667788, ON,  R, 4'h0, 8'h30, 32'h0,
                32'h0, FWD ? 32'h55660000 : 32'h00000000, 1'b0};
    tbl[6]  = '{ON, R, 4'h0, 8'h10, 32'h0,        ON,  R, 4'h0, 8'h30, 32'h0,        32'hDEADBEEF, 32'h55660000, 1'b0};
    tbl[7]  = '{ON, W, 4'h0, 8'h40, 32'hFFFFFFFF, ON,  W, 4'h5, 8'h41, 32'h01020304, 32'h0, 32'h0, 1'b0};
    tbl[8]  = '{ON, R, 4'h0, 8'h40, 32'h0,        ON,  R, 4'h0, 8'h41, 32'h0,        32'h0, 32'h00020004, 1'b0};
    tbl[9]  = '{ON, R, 4'h0, 8'h50, 32'h0,        ON,  W, 4'hF, 8'h50, 32'hCAFEF00D,
                FWD ? 32'hCAFEF00D : 32'h00000000, 32'h0, 1'b0};
    tbl[10] = '{ON, W, 4'h3, 8'h60, 32'hA1A2A3A4, ON,  W, 4'hC, 8'h60, 32'hB1B2B3B4, 32'h0, 32'h0, 1'b0};
    tbl[11] = '{ON, R, 4'h0, 8'h60, 32'h0,        ON,  R, 4'h0, 8'h50, 32'h0,        32'hB1B2A3A4, 32'hCAFEF00D, 1'b0};
    tbl[12] = '{ON, W, 4'h0, 8'h70, 32'hFFFFFFFF, ON,  W, 4'hF, 8'h70, 32'h12345678, 32'h0, 32'h0, 1'b0};
    tbl[13] = '{OFF, W, 4'hF, 8'h10, 32'h0,       OFF, W, 4'hF, 8'h20, 32'h0,        32'h0, 32'h0, 1'b0};
    tbl[14] = '{ON, R, 4'h0, 8'h70, 32'h0,        ON,  R, 4'h0, 8'h10, 32'h0,        32'h12345678, 32'hDEADBEEF, 1'b0};
    tbl[15] = '{ON, W, 4'h8, 8'h20, 32'hEE000000, ON,  W, 4'h9, 8'h20, 32'h77000066, 32'h0, 32'h0, 1'b1};
    tbl[16] = '{ON, R, 4'h0, 8'h20, 32'h0,        ON,  R, 4'h0, 8'h20, 32'h0,        32'h7722CC66, 32'h7722CC66, 1'b0};
    tbl[17] = '{ON, W, 4'hF, 8'hFE, 32'hFFFFFFFF, OFF, R, 4'h0, 8'h00, 32'h0,        32'h0, 32'h0, 1'b0};

    reset = 1'b1;
    idle_inputs();
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst:init_busy", 32'(init_busy), 32'd1);
    chk("rst:a_rd_valid", 32'(a_rd_valid), 32'd0);
    chk("rst:b_rd_valid", 32'(b_rd_valid), 32'd0);
    chk("rst:a_rd_data", a_rd_data, 32'h0);
    chk("rst:b_rd_data", b_rd_data, 32'h0);
    chk("rst:a_wr_conflict", 32'(a_wr_conflict), 32'd0);

    @(negedge clk);
    reset = 1'b0;
    count_busy(DEPTH + 16, n_busy, n_spur);
    chk("init:busy_cycles", 32'(n_busy), 32'(DEPTH));
    chk("init:no_valid_during_clear", 32'(n_spur), 32'd0);

    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("vec%0d", i));
    apply('{OFF, R, 4'h0, 8'h00, 32'h0, OFF, R, 4'h0, 8'h00, 32'h0, 32'h0, 32'h0, 1'b0}, "idle_hold");

    for (int i = 0; i < 16; i++) begin
      v = '{ON, W, 4'hF, 8'(8'h80 + i), 32'h0A000000 + 32'(i),
            ON, W, 4'hF, 8'(8'h90 + i), 32'h0B000000 + 32'(i), 32'h0, 32'h0, 1'b0};
      apply(v, $sformatf("b2b_wr%0d", i));
    end
    for (int i = 0; i < 16; i++) begin
      v = '{ON, R, 4'h0, 8'(8'h80 + i), 32'h0, ON, R, 4'h0, 8'(8'h9F - i), 32'h0,
            32'h0A000000 + 32'(i), 32'h0B000000 + 32'(15 - i), 1'b0};
      apply(v, $sformatf("b2b_rd%0d", i));
    end
    apply('{OFF, R, 4'h0, 8'h00, 32'h0, OFF, R, 4'h0, 8'h00, 32'h0, 32'h0, 32'h0, 1'b0}, "b2b_tail");

    // Reset lands between request and sampling edge: the read must never complete.
    @(negedge clk);
    a_as_ = 1'b0; a_rw = 1'b1; a_addr = 8'h10;
    b_as_ = 1'b0; b_rw = 1'b1; b_addr = 8'h20;
    #2;
    reset = 1'b1;
    reset_model();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outputs($sformatf("inflight%0d", i));
      chk("inflight:init_busy", 32'(init_busy), 32'd1);
    end

    @(negedge clk);
    reset = 1'b0;
    count_busy(100, n_busy, n_spur);
    chk("midclr:busy_cycles", 32'(n_busy), 32'd100);
    chk("midclr:no_valid", 32'(n_spur), 32'd0);
    chk("midclr:still_busy", 32'(init_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midclr:busy_in_reset", 32'(init_busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    count_busy(DEPTH + 16, n_busy, n_spur);
    chk("reclr:busy_cycles", 32'(n_busy), 32'(DEPTH));
    chk("reclr:no_valid", 32'(n_spur), 32'd0);

    apply('{ON, R, 4'h0, 8'hFE, 32'h0, ON, R, 4'h0, 8'h10, 32'h0, 32'h0, 32'h0, 1'b0}, "reclr_rd");
    apply('{ON, R, 4'h0, 8'h05, 32'h0, ON, R, 4'h0, 8'h60, 32'h0, 32'h0, 32'h0, 1'b0}, "reclr_rd2");
    apply('{OFF, R, 4'h0, 8'h00, 32'h0, OFF, R, 4'h0, 8'h00, 32'h0, 32'h0, 32'h0, 1'b0}, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
